// File: rtl/tdm_tx.sv
// Purpose : I2S / TDM serial audio transmitter; one NCH-sample frame per valid/ready transfer, sent MSB-first on sdo.
// Latency : sclk pin fall -> sdo update 3 clk; lrclk pin fall -> underrun pulse 3 clk.
// Backpress: s_ready = holding buffer empty; at most one frame is accepted per frame sync.
//
// Ports:
//   clk, rst            audio-domain clock (>= 4x sclk), async active-high reset
//   s_data/s_valid/s_ready  frame input, channel c = s_data[c*DW +: DW]
//   sclk, lrclk         external bit clock / frame sync, asynchronous to clk
//   sdo                 serial data out
//   underrun            one-cycle pulse when a frame sync finds no buffered frame
//   underrun_cnt        saturating underrun counter, only with TDM_TX_UNDERRUN_CNT_EN defined
module tdm_tx #(
    parameter int DW  = 24,
    parameter int SW  = 32,
    parameter int NCH = 2,
    parameter int FMT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              sclk,
    input  logic              lrclk,
    output logic              sdo,
    output logic              underrun
`ifdef TDM_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int TOT = NCH * SW;
    localparam int KW  = $clog2(TOT + 1);

    // Synchronisers followed by a one-register edge detector.
    logic [1:0] sclk_sync;
    logic [1:0] lr_sync;
    logic       sclk_d;
    logic       lr_d;
    logic       sclk_fall;
    logic       fs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            sclk_d    <= 1'b0;
            lr_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            lr_sync   <= {lr_sync[0], lrclk};
            sclk_d    <= sclk_sync[1];
            lr_d      <= lr_sync[1];
        end
    end

    assign sclk_fall = sclk_d & ~sclk_sync[1];
    assign fs        = lr_d & ~lr_sync[1];

    // Holding buffer. 'alive' keeps s_ready low until the first edge after reset.
    logic [NCH*DW-1:0] buf_dat;
    logic              full;
    logic              alive;
    logic              xfer;

    assign s_ready = alive & ~full;
    assign xfer    = s_valid & s_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_dat <= '0;
            full    <= 1'b0;
            alive   <= 1'b0;
        end else begin
            alive <= 1'b1;
            // A transfer can only happen with the buffer empty, so when it
            // coincides with FS the buffer was not loaded into the shifter
            // and the new frame waits here for the next FS.
            if (xfer) begin
                buf_dat <= s_data;
                full    <= 1'b1;
            end else if (fs) begin
                full    <= 1'b0;
            end
        end
    end

    // Slot layout of the frame as it goes on the wire: vector MSB is sent first,
    // each slot holds DW data bits MSB-first followed by SW-DW zero bits.
    // An empty buffer formats to all zeros, which is exactly the underrun frame.
    logic [TOT-1:0] load_vec;

    always_comb begin
        load_vec = '0;
        if (full) begin
            for (int c = 0; c < NCH; c++) begin
                for (int j = 0; j < DW; j++) begin
                    load_vec[TOT-1-c*SW-j] = buf_dat[c*DW+DW-1-j];
                end
            end
        end
    end

    // Shifter: sh[TOT-1] is the next bit to go out, k counts bits already sent.
    // k resets to TOT so no sclk edge can shift anything before the first FS.
    logic [TOT-1:0] sh;
    logic [KW-1:0]  k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            k        <= KW'(TOT);
            sdo      <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= fs & ~full;
            if (fs) begin
                // FS is edge n=0. Left-justified drives bit 0 right away; I2S
                // holds the previous value on n=0 and starts one edge later.
                if (FMT == 1) begin
                    sdo <= load_vec[TOT-1];
                    sh  <= load_vec << 1;
                    k   <= KW'(1);
                end else begin
                    sh  <= load_vec;
                    k   <= '0;
                end
            end else if (sclk_fall) begin
                if (k < KW'(TOT)) begin
                    sdo <= sh[TOT-1];
                    sh  <= sh << 1;
                    k   <= k + KW'(1);
                end else begin
                    // Long frame: pad with zeros until the next FS.
                    sdo <= 1'b0;
                end
            end
        end
    end

`ifdef TDM_TX_UNDERRUN_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule
